// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if
//   Bundles the CPU MEM-stage port, the debug/loader port and the RAM port
//   of the DRAM arbiter.
//   slave  modport: the arbiter side (consumes requests, drives RAM).
//   master modport: the environment side (CPU, debugger and RAM model).
//   Port groups:
//     cpu_* : CPU access request, load data and stall.
//     dbg_* : debug access request, lock, grant and registered read data.
//     ram_* : RAM command outputs and combinational read data ram_do.
interface dram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_e;
    logic              cpu_rw;
    logic [1:0]        cpu_size;
    logic              cpu_se;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_rw;
    logic [1:0]        dbg_size;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_locked;

    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_di;
    logic [1:0]        ram_size;
    logic              ram_rw;
    logic              ram_se;
    logic              ram_e;
    logic [DATA_W-1:0] ram_do;

    modport slave (
        input  cpu_e, cpu_rw, cpu_size, cpu_se, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_rw, dbg_size, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
        output ram_a, ram_di, ram_size, ram_rw, ram_se, ram_e,
        input  ram_do
    );

    modport master (
        output cpu_e, cpu_rw, cpu_size, cpu_se, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_rw, dbg_size, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
        input  ram_a, ram_di, ram_size, ram_rw, ram_se, ram_e,
        output ram_do
    );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares one single-port RAM between the CPU MEM stage and a debug/loader
//   port. The CPU normally has priority; a starvation counter forces one
//   debug access through after STARVE_MAX consecutive lost conflicts, and
//   the debug port can lock the RAM, halting the CPU.
//   Grant, RAM mux, cpu_stall and dbg_gnt are combinational, so a granted
//   access completes in the cycle it is presented. Debug read data is
//   registered and flagged by dbg_rvalid for one cycle.
// Ports:
//   clk   : single clock, rising edge.
//   reset : asynchronous, active-high.
//   bus   : dram_arbiter_if.slave (CPU, debug and RAM port groups).
module dram_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FORCE  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] starve_cnt;
    logic [2:0] starve_cnt_nxt;
    logic       dbg_win;
    logic       cpu_win;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // State register and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Next-state logic. The counter only survives NORMAL conflict cycles;
    // every other cycle (grant, no request, FORCE, LOCKED) clears it.
    always_comb begin
        state_nxt      = NORMAL;
        starve_cnt_nxt = '0;
        unique case (state)
            NORMAL: begin
                if (bus.cpu_e && bus.dbg_req)
                    starve_cnt_nxt = sat_inc(starve_cnt);
                // Move to FORCE on the same edge the count reaches the
                // limit, so the debug port wins the very next cycle.
                if (bus.dbg_lock)
                    state_nxt = LOCKED;
                else if (int'(starve_cnt_nxt) >= STARVE_MAX)
                    state_nxt = FORCE;
            end
            FORCE: begin
                if (bus.dbg_lock)
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                if (bus.dbg_lock)
                    state_nxt = LOCKED;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    // Output logic: arbitration, RAM mux and CPU-side responses
    always_comb begin
        dbg_win       = 1'b0;
        cpu_win       = 1'b0;
        bus.ram_a     = '0;
        bus.ram_di    = '0;
        bus.ram_size  = '0;
        bus.ram_rw    = 1'b0;
        bus.ram_se    = 1'b0;
        bus.ram_e     = 1'b0;
        if (!reset) begin
            dbg_win = bus.dbg_req &&
                      (state == FORCE || state == LOCKED || !bus.cpu_e);
            cpu_win = bus.cpu_e && !dbg_win && (state != LOCKED);
        end
        if (dbg_win) begin
            bus.ram_a    = bus.dbg_addr;
            bus.ram_di   = bus.dbg_wdata;
            bus.ram_size = bus.dbg_size;
            bus.ram_rw   = bus.dbg_rw;
            bus.ram_e    = 1'b1;
        end else if (cpu_win) begin
            bus.ram_a    = bus.cpu_addr;
            bus.ram_di   = bus.cpu_wdata;
            bus.ram_size = bus.cpu_size;
            bus.ram_rw   = bus.cpu_rw;
            bus.ram_se   = bus.cpu_se;
            bus.ram_e    = 1'b1;
        end
        bus.dbg_gnt    = dbg_win;
        // A CPU request that is not serviced (lost to debug, or held off
        // by the lock) must stall the pipeline.
        bus.cpu_stall  = !reset && bus.cpu_e && !cpu_win;
        bus.cpu_rdata  = cpu_win ? bus.ram_do : '0;
        bus.dbg_locked = (state == LOCKED);
    end

    // Debug read data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            bus.dbg_rvalid <= dbg_win && !bus.dbg_rw;
            if (dbg_win && !bus.dbg_rw)
                bus.dbg_rdata <= bus.ram_do;
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Scoreboard bench for dram_arbiter. Each stimulus cycle pushes its
//   hand-computed expected outputs into a queue; a monitor on the falling
//   edge pops and compares them. The RAM is a small word-addressed model.
module tb_dram_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] VV = 32'h12345678;
    localparam logic [8:0]  A1 = 9'h010;
    localparam logic [8:0]  A2 = 9'h020;

    typedef struct {
        string       name;
        logic        stall;
        logic        gnt;
        logic        ram_e;
        logic        rvalid;
        logic        locked;
        logic        chk_cd;
        logic [31:0] cpu_rdata;
        logic        chk_ram;
        logic        rw;
        logic [8:0]  a;
        logic        chk_dd;
        logic [31:0] dbg_rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t cur;
    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always_comb bus.ram_do = mem[bus.ram_a[8:2]];
    always @(posedge clk)
        if (bus.ram_e && bus.ram_rw)
            mem[bus.ram_a[8:2]] <= bus.ram_di;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", n, got, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic st, input logic g, input logic re,
                                input logic rv, input logic lk, input logic ccd, input logic [31:0] cd,
                                input logic cram, input logic rw, input logic [8:0] a,
                                input logic cdd, input logic [31:0] dd);
        exp_t x;
        x.name = n; x.stall = st; x.gnt = g; x.ram_e = re; x.rvalid = rv; x.locked = lk;
        x.chk_cd = ccd; x.cpu_rdata = cd; x.chk_ram = cram; x.rw = rw; x.a = a;
        x.chk_dd = cdd; x.dbg_rdata = dd;
        return x;
    endfunction

    task automatic cyc(input logic ce, input logic crw, input logic [8:0] ca,
                       input logic dr, input logic drw, input logic [8:0] da,
                       input logic [31:0] dw, input logic lk, input exp_t x);
        @(posedge clk);
        #1;
        bus.cpu_e = ce; bus.cpu_rw = crw; bus.cpu_addr = ca;
        bus.dbg_req = dr; bus.dbg_rw = drw; bus.dbg_addr = da; bus.dbg_wdata = dw;
        bus.dbg_lock = lk;
        sb.push_back(x);
    endtask

    // Monitor: compare outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk({cur.name, ".cpu_stall"},  32'(bus.cpu_stall),  32'(cur.stall));
            chk({cur.name, ".dbg_gnt"},    32'(bus.dbg_gnt),    32'(cur.gnt));
            chk({cur.name, ".ram_e"},      32'(bus.ram_e),      32'(cur.ram_e));
            chk({cur.name, ".dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(cur.rvalid));
            chk({cur.name, ".dbg_locked"}, 32'(bus.dbg_locked), 32'(cur.locked));
            if (cur.chk_cd)
                chk({cur.name, ".cpu_rdata"}, bus.cpu_rdata, cur.cpu_rdata);
            if (cur.chk_ram) begin
                chk({cur.name, ".ram_rw"}, 32'(bus.ram_rw), 32'(cur.rw));
                chk({cur.name, ".ram_a"},  32'(bus.ram_a),  32'(cur.a));
            end
            if (cur.chk_dd)
                chk({cur.name, ".dbg_rdata"}, bus.dbg_rdata, cur.dbg_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_e = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_size = 2'b10; bus.cpu_se = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_rw = 1'b0; bus.dbg_size = 2'b10; bus.dbg_addr = '0;
        bus.dbg_wdata = '0; bus.dbg_lock = 1'b0;

        // Reset values before any clock edge
        #2;
        chk("rst.cpu_stall",  32'(bus.cpu_stall),  32'd0);
        chk("rst.dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        chk("rst.ram_e",      32'(bus.ram_e),      32'd0);
        chk("rst.dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rst.dbg_rdata",  bus.dbg_rdata,       32'd0);
        chk("rst.dbg_locked", 32'(bus.dbg_locked), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Debug writes, CPU read, debug read with one-cycle-later data
        cyc(0,0,0,   1,1,A1,DB,0, mk("dbg_wr1",0,1,1,0,0, 0,0,  1,1,A1, 0,0));
        cyc(0,0,0,   1,1,A2,VV,0, mk("dbg_wr2",0,1,1,0,0, 0,0,  1,1,A2, 0,0));
        cyc(1,0,A1,  0,0,0,0,0,   mk("cpu_rd", 0,0,1,0,0, 1,DB, 1,0,A1, 0,0));
        cyc(0,0,0,   1,0,A2,0,0,  mk("dbg_rd", 0,1,1,0,0, 0,0,  1,0,A2, 0,0));
        cyc(0,0,0,   0,0,0,0,0,   mk("rvalid", 0,0,0,1,0, 1,0,  1,0,0,  1,VV));
        cyc(0,0,0,   0,0,0,0,0,   mk("idle",   0,0,0,0,0, 1,0,  1,0,0,  1,VV));

        // Continuous conflict: debug forced through every fifth cycle
        for (int k = 1; k <= 10; k++) begin
            if (k == 5 || k == 10)
                cyc(1,0,A1, 1,0,A2,0,0, mk("force",  1,1,1,0,0, 1,0,  1,0,A2, 0,0));
            else
                cyc(1,0,A1, 1,0,A2,0,0, mk("starve", 0,0,1,(k == 6),0, 1,DB, 1,0,A1, (k == 6),VV));
        end
        cyc(0,0,0,   0,0,0,0,0,   mk("post_starve",0,0,0,1,0, 1,0, 1,0,0, 1,VV));

        // Lock held six cycles with the CPU requesting throughout
        cyc(1,0,A1,  0,0,0,0,1,   mk("lock_entry",0,0,1,0,0, 1,DB, 1,0,A1, 0,0));
        cyc(1,0,A1,  0,0,0,0,1,   mk("locked",    1,0,0,0,1, 1,0,  1,0,0,  0,0));
        cyc(1,0,A1,  0,0,0,0,1,   mk("locked",    1,0,0,0,1, 1,0,  1,0,0,  0,0));
        cyc(1,0,A1,  1,0,A1,0,1,  mk("locked_dbg",1,1,1,0,1, 1,0,  1,0,A1, 0,0));
        cyc(1,0,A1,  0,0,0,0,1,   mk("locked_rv", 1,0,0,1,1, 1,0,  1,0,0,  1,DB));
        cyc(1,0,A1,  0,0,0,0,1,   mk("locked",    1,0,0,0,1, 1,0,  1,0,0,  1,DB));
        cyc(1,0,A1,  0,0,0,0,0,   mk("unlock_edge",1,0,0,0,1,1,0,  1,0,0,  0,0));
        cyc(1,0,A1,  0,0,0,0,0,   mk("unlocked",  0,0,1,0,0, 1,DB, 1,0,A1, 1,DB));
        cyc(0,0,0,   0,0,0,0,0,   mk("idle2",     0,0,0,0,0, 1,0,  1,0,0,  1,DB));

        // Reach FORCE, then assert reset mid-cycle
        for (int k = 1; k <= 4; k++)
            cyc(1,0,A1, 1,0,A2,0,0, mk("pre_force",0,0,1,0,0, 1,DB, 1,0,A1, 0,0));
        @(posedge clk);
        #1;
        chk("in_force.dbg_gnt",   32'(bus.dbg_gnt),   32'd1);
        chk("in_force.cpu_stall", 32'(bus.cpu_stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        chk("async_rst.cpu_stall",  32'(bus.cpu_stall),  32'd0);
        chk("async_rst.ram_e",      32'(bus.ram_e),      32'd0);
        chk("async_rst.cpu_rdata",  bus.cpu_rdata,       32'd0);
        chk("async_rst.dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("async_rst.dbg_rdata",  bus.dbg_rdata,       32'd0);
        chk("async_rst.dbg_locked", 32'(bus.dbg_locked), 32'd0);
        bus.cpu_e = 1'b0;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // After release the counter restarts: four CPU wins, then FORCE
        for (int k = 1; k <= 5; k++) begin
            if (k == 5)
                cyc(1,0,A1, 1,0,A2,0,0, mk("rst_force", 1,1,1,0,0, 1,0,  1,0,A2, 1,0));
            else
                cyc(1,0,A1, 1,0,A2,0,0, mk("post_rst",  0,0,1,0,0, 1,DB, 1,0,A1, 1,0));
        end
        cyc(0,0,0,   0,0,0,0,0,   mk("final_rv",0,0,0,1,0, 1,0, 1,0,0, 1,VV));

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
